ifu: RTL and testbench

- Instruction Fetch Unit at the front of the single-cycle RISC-V datapath.
- Holds the program counter (PC) and a byte-addressed, read-only instruction memory pre-loaded with a fixed program.
- Every cycle it presents the 32-bit instruction at PC to the decode stage and advances PC by 4.
- No branch or jump redirect input; strictly sequential fetch with wrap-around.

---
 rtl/ifu.sv | 57 +++++
 tb/tb_ifu.sv | 116 +++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: sequential PC with wrap-around and a fixed, byte-addressed
// read-only program memory assembled little-endian into a 32-bit instruction word.
module ifu #(
    parameter int          MEM_BYTES = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic [31:0] Instruction_Code
);

    localparam int AW = $clog2(MEM_BYTES);

    // Only the low AW bits of the PC are stored; the upper bits are always zero.
    logic [AW-1:0] pc_q = RESET_PC[AW-1:0];
    logic [AW-1:0] pc_d;

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        logic [31:0] addr;
        logic [31:0] word;
        addr = 32'(a);
        case (addr[31:2])
            30'd0:   word = 32'h0050_0093;
            30'd1:   word = 32'h0030_0113;
            30'd2:   word = 32'h0020_81B3;
            30'd3:   word = 32'h4020_8233;
            30'd4:   word = 32'h0020_F2B3;
            30'd5:   word = 32'h0020_E333;
            30'd6:   word = 32'h0020_C3B3;
            30'd7:   word = 32'h0000_0013;
            default: word = 32'h0000_0000;
        endcase
        case (addr[1:0])
            2'd0:    rom_byte = word[7:0];
            2'd1:    rom_byte = word[15:8];
            2'd2:    rom_byte = word[23:16];
            default: rom_byte = word[31:24];
        endcase
    endfunction

    always_comb begin
        pc_d = pc_q + AW'(4);
        if (RESET) begin
            pc_d = RESET_PC[AW-1:0];
        end
    end

    always_ff @(posedge CLOCK) begin
        pc_q <= pc_d;
    end

    assign Instruction_Code = {rom_byte(pc_q + AW'(3)),
                               rom_byte(pc_q + AW'(2)),
                               rom_byte(pc_q + AW'(1)),
                               rom_byte(pc_q)};

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset/clock alternation, reset hold, sequential fetch,
// wrap-around, mid-run reset and a reset pulse that falls between clock edges.
module tb_ifu;

    logic        CLOCK;
    logic        RESET;
    logic [31:0] Instruction_Code;

    int total = 0;
    int bad   = 0;

    ifu #(.MEM_BYTES(32), .RESET_PC(32'h0000_0000)) dut (
        .CLOCK            (CLOCK),
        .RESET            (RESET),
        .Instruction_Code (Instruction_Code)
    );

    // Rising edges at t = 40, 80, 120, ...
    initial begin
        CLOCK = 1'b0;
        #20;
        forever #20 CLOCK = ~CLOCK;
    end

    task automatic tick();
        @(posedge CLOCK);
        #10;
    endtask

    task automatic chk(input string tag, input logic [31:0] exp);
        total++;
        assert (Instruction_Code === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, Instruction_Code, exp);
        end
    endtask

    initial begin
        logic [31:0] prog [8];
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h0030_0113;
        prog[2] = 32'h0020_81B3;
        prog[3] = 32'h4020_8233;
        prog[4] = 32'h0020_F2B3;
        prog[5] = 32'h0020_E333;
        prog[6] = 32'h0020_C3B3;
        prog[7] = 32'h0000_0013;

        RESET = 1'b0;
        #10;
        chk("power_on", 32'h0050_0093);
        #10;
        RESET = 1'b1;                         // t = 20
        #10;
        chk("pre_first_edge", 32'h0050_0093); // t = 30

        // Reset edges at 40..200, sampled at 50..210
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("alt_reset_hold", 32'h0050_0093);
        end
        #10;
        RESET = 1'b0;                         // t = 220
        tick();                               // edge 240
        chk("alt_t240", 32'h0030_0113);
        tick();                               // edge 280
        chk("alt_t280", 32'h0020_81B3);
        #30;
        RESET = 1'b1;                         // t = 320
        tick();                               // edge 360
        chk("alt_t360", 32'h0050_0093);

        // Reset held for 4 more edges (5 total)
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("reset_hold", 32'h0050_0093);
        end

        RESET = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("seq_fetch", prog[i]);
        end
        tick();
        chk("wrap_to_0", 32'h0050_0093);
        tick();
        chk("wrap_then_4", 32'h0030_0113);

        // PC = 4; run to 0x10
        tick();
        tick();
        tick();
        chk("run_to_0x10", 32'h0020_F2B3);
        RESET = 1'b1;
        tick();
        chk("mid_reset", 32'h0050_0093);
        RESET = 1'b0;
        tick();
        chk("after_mid_reset", 32'h0030_0113);

        // Reset pulse entirely between edges must be ignored
        RESET = 1'b1;
        #5;
        chk("pulse_no_effect", 32'h0030_0113);
        RESET = 1'b0;
        tick();
        chk("pulse_seq_1", 32'h0020_81B3);
        tick();
        chk("pulse_seq_2", 32'h4020_8233);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
